// File: rtl/m_ext_ctrl.sv
// Sequencer between the EX stage and a multicycle RISC-V M-extension unit.
// Latches one op, drives the unit until ready, short-circuits divide special cases, and guards with a watchdog.

`ifndef INST_ID_LEN
`define INST_ID_LEN 6
`endif
`ifndef MUL_ID
`define MUL_ID    32
`define MULH_ID   33
`define MULHSU_ID 34
`define MULHU_ID  35
`define DIV_ID    36
`define DIVU_ID   37
`define REM_ID    38
`define REMU_ID   39
`endif

module m_ext_ctrl #(
    parameter int GPR_WIDTH = 32,
    parameter int ID_LEN    = `INST_ID_LEN,
    parameter int WDOG_CYC  = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic [ID_LEN-1:0]    instr_id_i,
    input  logic [GPR_WIDTH-1:0] rs1_i,
    input  logic [GPR_WIDTH-1:0] rs2_i,
    input  logic [4:0]           rd_i,
    input  logic                 flush_i,
    output logic                 stall_o,
    output logic                 res_valid_o,
    output logic [GPR_WIDTH-1:0] res_o,
    output logic [4:0]           rd_o,
    output logic                 err_o,
    output logic                 m_ce_o,
    output logic [ID_LEN-1:0]    m_instr_id_o,
    output logic [GPR_WIDTH-1:0] m_rs1_o,
    output logic [GPR_WIDTH-1:0] m_rs2_o,
    input  logic                 m_ready_i,
    input  logic [GPR_WIDTH-1:0] m_result_i
);

    localparam logic [ID_LEN-1:0] L_MUL  = ID_LEN'(`MUL_ID);
    localparam logic [ID_LEN-1:0] L_DIV  = ID_LEN'(`DIV_ID);
    localparam logic [ID_LEN-1:0] L_REM  = ID_LEN'(`REM_ID);
    localparam logic [ID_LEN-1:0] L_REMU = ID_LEN'(`REMU_ID);

    localparam logic [GPR_WIDTH-1:0] INT_MIN  = {1'b1, {(GPR_WIDTH-1){1'b0}}};
    localparam logic [GPR_WIDTH-1:0] ALL_ONES = {GPR_WIDTH{1'b1}};

    localparam int WD_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [ID_LEN-1:0]     r_id;
    logic [GPR_WIDTH-1:0]  r_rs1;
    logic [GPR_WIDTH-1:0]  r_rs2;
    logic [4:0]            r_rd;
    logic [GPR_WIDTH-1:0]  r_res;
    logic                  r_err;
    logic [WD_W-1:0]       r_wdog;

    logic                  w_is_m;
    logic                  w_accept;
    logic                  w_is_div;
    logic                  w_is_rem;
    logic                  w_is_sgn;
    logic                  w_by_zero;
    logic                  w_ovf;
    logic                  w_special;
    logic [GPR_WIDTH-1:0]  w_special_res;
    logic                  w_in_wait;
    logic                  w_wdog_hit;

    // Decode of the incoming request. Ids run MUL..REMU contiguously, divides last.
    always_comb begin
        w_is_m    = valid_i && (instr_id_i >= L_MUL) && (instr_id_i <= L_REMU);
        w_accept  = (r_state == S_IDLE) && w_is_m && !flush_i;
        w_is_div  = (instr_id_i >= L_DIV);
        w_is_rem  = (instr_id_i == L_REM) || (instr_id_i == L_REMU);
        w_is_sgn  = (instr_id_i == L_DIV) || (instr_id_i == L_REM);
        w_by_zero = (rs2_i == '0);
        w_ovf     = w_is_sgn && (rs1_i == INT_MIN) && (rs2_i == ALL_ONES);
        w_special = w_is_div && (w_by_zero || w_ovf);

        if (w_by_zero) begin
            w_special_res = w_is_rem ? rs1_i : ALL_ONES;
        end else begin
            w_special_res = w_is_rem ? '0 : INT_MIN;
        end
    end

    always_comb begin
        w_in_wait  = (r_state == S_WAIT);
        w_wdog_hit = (WDOG_CYC != 0) && w_in_wait && (r_wdog == WD_W'(WDOG_CYC - 1));
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; flush beats ready, ready beats the watchdog.
    // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_special ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush_i) begin
                    w_next = S_IDLE;
                end else if (m_ready_i || w_wdog_hit) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand latch, result capture, watchdog counter and sticky error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_id   <= '0;
            r_rs1  <= '0;
            r_rs2  <= '0;
            r_rd   <= '0;
            r_res  <= '0;
            r_err  <= 1'b0;
            r_wdog <= '0;
        end else begin
            if (w_accept) begin
                r_id  <= instr_id_i;
                r_rs1 <= rs1_i;
                r_rs2 <= rs2_i;
                r_rd  <= rd_i;
                if (w_special) begin
                    r_res <= w_special_res;
                end
            end

            if (w_in_wait && !flush_i) begin
                if (m_ready_i) begin
                    r_res <= m_result_i;
                end else if (w_wdog_hit) begin
                    r_res <= '0;
                    r_err <= 1'b1;
                end
            end

            if (w_in_wait && (w_next == S_WAIT)) begin
                r_wdog <= r_wdog + WD_W'(1);
            end else begin
                r_wdog <= '0;
            end
        end
    end

    // Outputs; stall covers the accept cycle combinationally so EX holds immediately.
    always_comb begin
        stall_o      = w_accept || w_in_wait;
        m_ce_o       = w_in_wait;
        res_valid_o  = (r_state == S_DONE) && !flush_i;
        res_o        = r_res;
        rd_o         = r_rd;
        err_o        = r_err;
        m_instr_id_o = r_id;
        m_rs1_o      = r_rs1;
        m_rs2_o      = r_rs2;
    end

endmodule

// File: tb/tb_m_ext_ctrl.sv
// Self-checking bench for m_ext_ctrl: a per-cycle expectation timeline plus a RISC-V M-op reference function.
// The bench plays the role of the M unit and drives m_ready_i/m_result_i itself.

`ifndef INST_ID_LEN
`define INST_ID_LEN 6
`endif
`ifndef MUL_ID
`define MUL_ID    32
`define MULH_ID   33
`define MULHSU_ID 34
`define MULHU_ID  35
`define DIV_ID    36
`define DIVU_ID   37
`define REM_ID    38
`define REMU_ID   39
`endif

module tb_m_ext_ctrl;

    localparam int GW = 32;
    localparam int IL = `INST_ID_LEN;
    localparam int WD = 8;

    localparam logic [IL-1:0] ID_MUL    = IL'(`MUL_ID);
    localparam logic [IL-1:0] ID_MULH   = IL'(`MULH_ID);
    localparam logic [IL-1:0] ID_MULHSU = IL'(`MULHSU_ID);
    localparam logic [IL-1:0] ID_MULHU  = IL'(`MULHU_ID);
    localparam logic [IL-1:0] ID_DIV    = IL'(`DIV_ID);
    localparam logic [IL-1:0] ID_DIVU   = IL'(`DIVU_ID);
    localparam logic [IL-1:0] ID_REM    = IL'(`REM_ID);
    localparam logic [IL-1:0] ID_REMU   = IL'(`REMU_ID);

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          valid_i;
    logic [IL-1:0] instr_id_i;
    logic [GW-1:0] rs1_i;
    logic [GW-1:0] rs2_i;
    logic [4:0]    rd_i;
    logic          flush_i;
    logic          stall_o;
    logic          res_valid_o;
    logic [GW-1:0] res_o;
    logic [4:0]    rd_o;
    logic          err_o;
    logic          m_ce_o;
    logic [IL-1:0] m_instr_id_o;
    logic [GW-1:0] m_rs1_o;
    logic [GW-1:0] m_rs2_o;
    logic          m_ready_i;
    logic [GW-1:0] m_result_i;

    m_ext_ctrl #(.GPR_WIDTH(GW), .ID_LEN(IL), .WDOG_CYC(WD)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .instr_id_i   (instr_id_i),
        .rs1_i        (rs1_i),
        .rs2_i        (rs2_i),
        .rd_i         (rd_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .res_valid_o  (res_valid_o),
        .res_o        (res_o),
        .rd_o         (rd_o),
        .err_o        (err_o),
        .m_ce_o       (m_ce_o),
        .m_instr_id_o (m_instr_id_o),
        .m_rs1_o      (m_rs1_o),
        .m_rs2_o      (m_rs2_o),
        .m_ready_i    (m_ready_i),
        .m_result_i   (m_result_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;
    int n_pulses = 0;
    int rv_count = 0;

    logic          chk_en = 1'b0;
    logic          exp_stall = 1'b0;
    logic          exp_ce = 1'b0;
    logic          exp_rv = 1'b0;
    logic          exp_err = 1'b0;
    logic [GW-1:0] exp_res = '0;
    logic [4:0]    exp_rd = '0;
    logic [IL-1:0] exp_id = '0;
    logic [GW-1:0] exp_rs1 = '0;
    logic [GW-1:0] exp_rs2 = '0;
    logic [GW-1:0] last_res = '0;
    logic [4:0]    last_rd = '0;

    task automatic check(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // RISC-V M-extension semantics, including the divide special cases.
    function automatic logic [GW-1:0] ref_m(input logic [IL-1:0] id, input logic [GW-1:0] a, input logic [GW-1:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        p;
        int                 ia;
        int                 ib;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        ia = a;
        ib = b;
        p  = '0;
        if (id == ID_MUL)    begin p = sa * sb; return p[31:0]; end
        if (id == ID_MULH)   begin p = sa * sb; return p[63:32]; end
        if (id == ID_MULHSU) begin p = sa * $signed({32'b0, b}); return p[63:32]; end
        if (id == ID_MULHU)  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
        if (id == ID_DIV) begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(ia / ib);
        end
        if (id == ID_DIVU) return (b == 0) ? 32'hFFFF_FFFF : a / b;
        if (id == ID_REM) begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(ia % ib);
        end
        if (id == ID_REMU) return (b == 0) ? a : a % b;
        return '0;
    endfunction

    // Single compare process: every cycle, mid-period, against the expectation timeline.
    always @(negedge clk_i) begin
        if (chk_en) begin
            check("stall_o", {31'b0, stall_o}, {31'b0, exp_stall});
            check("m_ce_o", {31'b0, m_ce_o}, {31'b0, exp_ce});
            check("res_valid_o", {31'b0, res_valid_o}, {31'b0, exp_rv});
            check("err_o", {31'b0, err_o}, {31'b0, exp_err});
            if (exp_rv) begin
                check("res_o", res_o, exp_res);
                check("rd_o", {27'b0, rd_o}, {27'b0, exp_rd});
            end
            if (exp_ce) begin
                check("m_instr_id_o", GW'(m_instr_id_o), GW'(exp_id));
                check("m_rs1_o", m_rs1_o, exp_rs1);
                check("m_rs2_o", m_rs2_o, exp_rs2);
            end
            if (res_valid_o) begin
                rv_count++;
                last_res = res_o;
                last_rd  = rd_o;
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_cycle();
        tick();
        valid_i   = 1'b0;
        flush_i   = 1'b0;
        m_ready_i = 1'b0;
        exp_stall = 1'b0;
        exp_ce    = 1'b0;
        exp_rv    = 1'b0;
    endtask

    task automatic issue(input logic [IL-1:0] id, input logic [GW-1:0] a, input logic [GW-1:0] b, input logic [4:0] rd);
        tick();
        valid_i    = 1'b1;
        instr_id_i = id;
        rs1_i      = a;
        rs2_i      = b;
        rd_i       = rd;
        flush_i    = 1'b0;
        m_ready_i  = 1'b1;          // ignored outside WAIT
        m_result_i = 32'hDEAD_BEEF;
        exp_stall  = 1'b1;
        exp_ce     = 1'b0;
        exp_rv     = 1'b0;
        exp_id     = id;
        exp_rs1    = a;
        exp_rs2    = b;
    endtask

    task automatic wait_cycle(input bit rdy, input logic [GW-1:0] r, input bit flush);
        tick();
        valid_i    = 1'b0;
        instr_id_i = ID_MUL;
        rs1_i      = $urandom;
        rs2_i      = $urandom;
        rd_i       = 5'($urandom);
        m_ready_i  = rdy;
        m_result_i = rdy ? r : $urandom;
        flush_i    = flush;
        exp_stall  = 1'b1;
        exp_ce     = 1'b1;
        exp_rv     = 1'b0;
    endtask

    task automatic unit_op(input logic [IL-1:0] id, input logic [GW-1:0] a, input logic [GW-1:0] b,
                           input logic [4:0] rd, input int lat, input bit flush_at_ready);
        logic [GW-1:0] r;
        r = ref_m(id, a, b);
        issue(id, a, b, rd);
        for (int k = 1; k <= lat; k++) begin
            wait_cycle(k == lat, r, flush_at_ready && (k == lat));
        end
        tick();
        m_ready_i = 1'b0;
        flush_i   = 1'b0;
        exp_stall = 1'b0;
        exp_ce    = 1'b0;
        exp_rv    = !flush_at_ready;
        exp_res   = r;
        exp_rd    = rd;
        if (!flush_at_ready) n_pulses++;
        idle_cycle();
    endtask

    // Special-case op; a second request is presented in DONE and must be ignored.
    task automatic special_op(input logic [IL-1:0] id, input logic [GW-1:0] a, input logic [GW-1:0] b,
                              input logic [4:0] rd, input bit flush_in_done);
        logic [GW-1:0] r;
        r = ref_m(id, a, b);
        issue(id, a, b, rd);
        m_ready_i = 1'b0;
        tick();
        valid_i    = 1'b1;
        instr_id_i = ID_MUL;
        rs1_i      = 32'd3;
        rs2_i      = 32'd4;
        flush_i    = flush_in_done;
        exp_stall  = 1'b0;
        exp_ce     = 1'b0;
        exp_rv     = !flush_in_done;
        exp_res    = r;
        exp_rd     = rd;
        if (!flush_in_done) n_pulses++;
        idle_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i      = 1'b1;
        valid_i    = 1'b0;
        instr_id_i = '0;
        rs1_i      = '0;
        rs2_i      = '0;
        rd_i       = '0;
        flush_i    = 1'b0;
        m_ready_i  = 1'b0;
        m_result_i = '0;

        repeat (2) @(posedge clk_i);
        #1;
        check("reset stall_o", {31'b0, stall_o}, 32'd0);
        check("reset m_ce_o", {31'b0, m_ce_o}, 32'd0);
        check("reset res_valid_o", {31'b0, res_valid_o}, 32'd0);
        check("reset res_o", res_o, 32'd0);
        check("reset rd_o", {27'b0, rd_o}, 32'd0);
        check("reset err_o", {31'b0, err_o}, 32'd0);
        check("reset m_rs1_o", m_rs1_o, 32'd0);
        tick();
        rst_i  = 1'b0;
        chk_en = 1'b1;

        unit_op(ID_MUL, 32'hFFFF_FFFD, 32'd7, 5'd5, 3, 1'b0);
        check("lit MUL -3*7", last_res, 32'hFFFF_FFEB);
        check("lit MUL rd", {27'b0, last_rd}, 32'd5);

        unit_op(ID_MULH, 32'h8000_0000, 32'h8000_0000, 5'd1, 1, 1'b0);
        check("lit MULH", last_res, 32'h4000_0000);
        unit_op(ID_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 2, 1'b0);
        check("lit MULHSU", last_res, 32'hFFFF_FFFF);
        unit_op(ID_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3, 4, 1'b0);
        check("lit DIV -7/2", last_res, 32'hFFFF_FFFD);
        unit_op(ID_REM, 32'hFFFF_FFF9, 32'd2, 5'd4, 2, 1'b0);
        check("lit REM -7%2", last_res, 32'hFFFF_FFFF);
        unit_op(ID_REMU, 32'd100, 32'd7, 5'd6, 1, 1'b0);
        check("lit REMU 100%7", last_res, 32'd2);

        special_op(ID_DIV, 32'd100, 32'd0, 5'd7, 1'b0);
        check("lit DIV by 0", last_res, 32'hFFFF_FFFF);
        special_op(ID_REMU, 32'd9, 32'd0, 5'd8, 1'b0);
        check("lit REMU by 0", last_res, 32'd9);
        special_op(ID_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b0);
        check("lit DIV overflow", last_res, 32'h8000_0000);
        special_op(ID_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b0);
        check("lit REM overflow", last_res, 32'd0);
        special_op(ID_DIVU, 32'd5, 32'd0, 5'd11, 1'b1);

        // Flush together with ready in WAIT: result dropped, unit released.
        unit_op(ID_DIVU, 32'd1000, 32'd10, 5'd12, 3, 1'b1);

        // Non-M id and flushed request: neither is accepted.
        tick();
        valid_i    = 1'b1;
        instr_id_i = IL'(5);
        exp_stall  = 1'b0;
        idle_cycle();
        tick();
        valid_i    = 1'b1;
        instr_id_i = ID_MUL;
        flush_i    = 1'b1;
        exp_stall  = 1'b0;
        idle_cycle();
        idle_cycle();

        // Hung unit: watchdog fires after WD WAIT cycles.
        issue(ID_MUL, 32'd6, 32'd7, 5'd13);
        m_ready_i = 1'b0;
        for (int k = 1; k <= WD; k++) begin
            wait_cycle(1'b0, '0, 1'b0);
        end
        tick();
        exp_stall = 1'b0;
        exp_ce    = 1'b0;
        exp_rv    = 1'b1;
        exp_res   = '0;
        exp_rd    = 5'd13;
        exp_err   = 1'b1;
        n_pulses++;
        idle_cycle();
        check("lit watchdog res", last_res, 32'd0);
        idle_cycle();

        // Reset in the middle of WAIT.
        issue(ID_DIVU, 32'd50, 32'd7, 5'd14);
        m_ready_i = 1'b0;
        wait_cycle(1'b0, '0, 1'b0);
        wait_cycle(1'b0, '0, 1'b0);
        #2;
        rst_i = 1'b1;
        #1;
        check("async rst stall_o", {31'b0, stall_o}, 32'd0);
        check("async rst m_ce_o", {31'b0, m_ce_o}, 32'd0);
        check("async rst res_valid_o", {31'b0, res_valid_o}, 32'd0);
        check("async rst err_o", {31'b0, err_o}, 32'd0);
        check("async rst res_o", res_o, 32'd0);
        exp_stall = 1'b0;
        exp_ce    = 1'b0;
        exp_rv    = 1'b0;
        exp_err   = 1'b0;
        tick();
        rst_i = 1'b0;
        idle_cycle();

        unit_op(ID_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd15, 2, 1'b0);
        check("lit MULHU", last_res, 32'd1);

        idle_cycle();
        @(negedge clk_i);
        #1;
        chk_en = 1'b0;
        check("res_valid pulse count", rv_count, n_pulses);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
